mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//  Multi-cycle memory/peripheral bus controller between the CPU load/store port and the board devices.
//  Devices: two SRAM banks (base/ext), CPLD UART, LED and DPY registers.
//  Uses a req/ack handshake with a parametrised SRAM wait count and UART strobe width.
//  Adds byte/half lane steering with sign/zero extension, and registered strobes so the
//  board sees no clock-phase glitches.
// PARAMETERS
//  SRAM_AW    20            SRAM word-address width; bank address = addr[SRAM_AW+1:2]
//  BANK_BIT   22            addr bit selecting ext (1) or base (0) SRAM
//  SRAM_WAIT  2             cycles ce_n/oe_n or ce_n/we_n held low per SRAM access (>=1)
//  UART_PULSE 2             cycles uart_rdn/uart_wrn held low per UART access (>=1)
//  UART_DATA  32'hBFD003F8  UART data register address
//  UART_STAT  32'hBFD003FC  UART status register address
//  LED_ADDR   32'hBFD00400  LED register address
//  DPY_ADDR   32'hBFD00408  DPY register address
//  IO_MASK    32'hFFFF0000  addr&IO_MASK==32'hBFD00000 selects I/O space
// PORTS
//  clk            in     1   system clock
//  rst_n          in     1   asynchronous active-low reset
//  req            in     1   request valid; sampled only in IDLE
//  we             in     1   1=write, 0=read
//  addr           in     32  byte address
//  wdata          in     32  write data (LSB-aligned for byte/half)
//  bytemode       in     5   [3:0] lane mask, [4] 1=zero-extend read
//  rdata          out    32  read data, valid while ack=1, then held
//  ack            out    1   one-cycle completion pulse
//  base_ram_*     io/out     data[32] inout, addr[SRAM_AW], be_n[4], ce_n, oe_n, we_n
//  ext_ram_*      io/out     same as base_ram_*
//  uart_rdn       out    1   UART read strobe (active low)
//  uart_wrn       out    1   UART write strobe (active low)
//  uart_dataready in     1   RX byte available
//  uart_tbre      in     1   TX buffer empty
//  uart_tsre      in     1   TX shift register empty
//  debug_leds     out    16  LED register
//  debug_dpys     out    8   DPY register
// BEHAVIOUR
//  Reset (async, immediate):
//   - all *_n strobes = 1; both RAM data buses = Z; FSM = IDLE.
//   - ack, rdata, debug_leds, debug_dpys = 0.
//   - Reset mid-access aborts the access with no ack.
//  Latching: IDLE & req latches addr/we/wdata/bytemode. Inputs are ignored until the FSM returns to IDLE.
//  FSM states: IDLE, SRAM, UART_WAIT, UART, DONE.
//  Decode from IDLE:
//   - I/O-space UART_DATA -> UART_WAIT.
//   - UART_STAT, LED, DPY, and unmapped I/O -> DONE.
//   - everything else -> SRAM.
//  SRAM:
//   - Selected bank ce_n=0 plus oe_n=0 (read) or we_n=0 (write) for SRAM_WAIT cycles.
//   - Other bank is fully deasserted.
//   - be_n = ~bytemode[3:0].
//   - Read data is captured on the last SRAM cycle.
//   - Write data drives the bus from the first SRAM cycle through DONE; we_n rises in DONE (hold).
//  UART_WAIT:
//   - Read: wait for uart_dataready.
//   - Write: wait for uart_tbre & uart_tsre.
//   - Then -> UART. No timeout.
//  UART:
//   - Both SRAM ce_n = 1.
//   - rdn or wrn low for UART_PULSE cycles; data path on base_ram_data[7:0].
//   - Write drives {24'b0, wdata[7:0]}; read captures {24'b0, base_ram_data[7:0]} on the last cycle.
//  DONE: ack = 1 for exactly one cycle, strobes high, -> IDLE.
//  Latency from the req cycle to the ack cycle:
//   - SRAM: SRAM_WAIT+1.
//   - Register/status: 1.
//   - UART: wait cycles + UART_PULSE + 1.
//   - Throughput: ack is followed by a mandatory IDLE cycle. req held high through ack starts a new access.
//  Read steering (rdata):
//   - Mask 0001/0010/0100/1000 selects byte lane 0/1/2/3; mask 0011/1100 selects half lane 0/1.
//   - The selected lane is shifted to bit 0 and sign-extended unless bytemode[4]=1 (then zero-extended).
//   - Any other mask returns the full word.
//  Write steering: byte/half wdata is replicated into the selected lanes; other masks pass wdata unchanged.
//  Register reads:
//   - UART_STAT: {30'b0, uart_dataready, uart_tbre & uart_tsre}.
//   - LED: {16'b0, leds}.
//   - DPY: {24'b0, dpys}.
//   - Unmapped I/O: 0.
//  Register writes: LED <= wdata[15:0], DPY <= wdata[7:0], applied on entry to DONE. Writes to unmapped I/O are ignored.
//  No alignment check; misaligned masks are driven as given.
// TESTING
//  - SRAM_WAIT=2. Write 0xDEADBEEF to 0x80000010, then read word:
//    base ce_n/we_n low 2 cycles, ack at req+3, rdata=0xDEADBEEF, ext strobes high.
//  - Byte store 0x80 to 0x80400003 (mask 1000), then lb and lbu:
//    ext be_n=0111; lb rdata=0xFFFFFF80, lbu rdata=0x00000080.
//  - UART write 0x41 with tsre=0 for 5 cycles:
//    wrn stays high until tsre&tbre=1, then low for UART_PULSE cycles; data[7:0]=0x41; single ack.
//  - Status read with dataready=1, tbre=tsre=1 -> rdata=0x00000003 at req+1.
//    UART read: rdn low UART_PULSE cycles, rdata=byte.
//  - LED write 0x1234 -> debug_leds=0x1234 at the ack cycle; LED read returns 0x00001234.
//  - Assert rst_n=0 during the 2nd SRAM cycle of a write:
//    we_n/ce_n high and bus Z immediately, no ack, LEDs=0; next req is served normally.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Multi-cycle CPU load/store bus controller for two SRAM banks, CPLD UART and LED/DPY registers.
// All board strobes and bus enables are flop outputs, decoded one cycle ahead from the next state.
module mem_bus_ctrl #(
  parameter int          SRAM_AW    = 20,
  parameter int          BANK_BIT   = 22,
  parameter int          SRAM_WAIT  = 2,
  parameter int          UART_PULSE = 2,
  parameter logic [31:0] UART_DATA  = 32'hBFD003F8,
  parameter logic [31:0] UART_STAT  = 32'hBFD003FC,
  parameter logic [31:0] LED_ADDR   = 32'hBFD00400,
  parameter logic [31:0] DPY_ADDR   = 32'hBFD00408,
  parameter logic [31:0] IO_MASK    = 32'hFFFF0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               we,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic [4:0]         bytemode,
  output logic [31:0]        rdata,
  output logic               ack,
  inout  wire  [31:0]        base_ram_data,
  output logic [SRAM_AW-1:0] base_ram_addr,
  output logic [3:0]         base_ram_be_n,
  output logic               base_ram_ce_n,
  output logic               base_ram_oe_n,
  output logic               base_ram_we_n,
  inout  wire  [31:0]        ext_ram_data,
  output logic [SRAM_AW-1:0] ext_ram_addr,
  output logic [3:0]         ext_ram_be_n,
  output logic               ext_ram_ce_n,
  output logic               ext_ram_oe_n,
  output logic               ext_ram_we_n,
  output logic               uart_rdn,
  output logic               uart_wrn,
  input  logic               uart_dataready,
  input  logic               uart_tbre,
  input  logic               uart_tsre,
  output logic [15:0]        debug_leds,
  output logic [7:0]         debug_dpys
);

  localparam logic [31:0] IO_BASE = 32'hBFD00000;

  typedef enum logic [2:0] {IDLE, SRAM, UART_WAIT, UART, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic [31:0] lat_addr, lat_wdata;
  logic        lat_we;
  logic [4:0]  lat_bm;

  // In IDLE the request is decoded straight from the inputs so the first strobe can be registered.
  logic [31:0] cur_addr;
  logic        cur_we;
  logic [4:0]  cur_bm;
  logic        cur_io, cur_uart, cur_bank;
  logic        sram_last, uart_last;

  assign cur_addr  = (state == IDLE) ? addr     : lat_addr;
  assign cur_we    = (state == IDLE) ? we       : lat_we;
  assign cur_bm    = (state == IDLE) ? bytemode : lat_bm;
  assign cur_io    = (cur_addr & IO_MASK) == IO_BASE;
  assign cur_uart  = cur_io && (cur_addr == UART_DATA);
  assign cur_bank  = cur_addr[BANK_BIT];
  assign sram_last = cnt == 8'(SRAM_WAIT - 1);
  assign uart_last = cnt == 8'(UART_PULSE - 1);

  function automatic logic [31:0] steer_rd(input logic [31:0] w, input logic [4:0] bm);
    logic [7:0]  b;
    logic [15:0] h;
    b = bm[0] ? w[7:0] : bm[1] ? w[15:8] : bm[2] ? w[23:16] : w[31:24];
    h = bm[0] ? w[15:0] : w[31:16];
    case (bm[3:0])
      4'b0001, 4'b0010, 4'b0100, 4'b1000: steer_rd = {{24{b[7] & ~bm[4]}}, b};
      4'b0011, 4'b1100:                   steer_rd = {{16{h[15] & ~bm[4]}}, h};
      default:                            steer_rd = w;
    endcase
  endfunction

  function automatic logic [31:0] steer_wr(input logic [31:0] w, input logic [3:0] m);
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: steer_wr = {4{w[7:0]}};
      4'b0011, 4'b1100:                   steer_wr = {2{w[15:0]}};
      default:                            steer_wr = w;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_we    <= 1'b0;
      lat_bm    <= 5'd0;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state) ? 8'd0 : cnt + 8'd1;
      if (state == IDLE && req) begin
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_we    <= we;
        lat_bm    <= bytemode;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (req) state_next = cur_uart ? UART_WAIT : (cur_io ? DONE : SRAM);
      SRAM:      if (sram_last) state_next = DONE;
      UART_WAIT: if (cur_we ? (uart_tbre && uart_tsre) : uart_dataready) state_next = UART;
      UART:      if (uart_last) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  logic       base_ce_d, base_oe_d, base_we_d, ext_ce_d, ext_oe_d, ext_we_d;
  logic       rdn_d, wrn_d, base_drv_d, ext_drv_d, ack_d;
  logic [3:0] base_be_d, ext_be_d;
  logic       base_drv, ext_drv;
  logic       in_sram, sram_hold;

  always_comb begin
    in_sram    = state_next == SRAM;
    sram_hold  = !cur_io && (state_next == SRAM || state_next == DONE);
    base_ce_d  = !(in_sram && !cur_bank);
    base_oe_d  = !(in_sram && !cur_bank && !cur_we);
    base_we_d  = !(in_sram && !cur_bank && cur_we);
    base_be_d  = (in_sram && !cur_bank) ? ~cur_bm[3:0] : 4'hF;
    ext_ce_d   = !(in_sram && cur_bank);
    ext_oe_d   = !(in_sram && cur_bank && !cur_we);
    ext_we_d   = !(in_sram && cur_bank && cur_we);
    ext_be_d   = (in_sram && cur_bank) ? ~cur_bm[3:0] : 4'hF;
    rdn_d      = !(state_next == UART && !cur_we);
    wrn_d      = !(state_next == UART && cur_we);
    base_drv_d = cur_we && ((sram_hold && !cur_bank) ||
                            (cur_uart && (state_next == UART || state_next == DONE)));
    ext_drv_d  = cur_we && sram_hold && cur_bank;
    ack_d      = state_next == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {base_ram_ce_n, base_ram_oe_n, base_ram_we_n} <= 3'b111;
      {ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}    <= 3'b111;
      base_ram_be_n <= 4'hF;
      ext_ram_be_n  <= 4'hF;
      uart_rdn      <= 1'b1;
      uart_wrn      <= 1'b1;
      base_drv      <= 1'b0;
      ext_drv       <= 1'b0;
      ack           <= 1'b0;
    end else begin
      {base_ram_ce_n, base_ram_oe_n, base_ram_we_n} <= {base_ce_d, base_oe_d, base_we_d};
      {ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}    <= {ext_ce_d, ext_oe_d, ext_we_d};
      base_ram_be_n <= base_be_d;
      ext_ram_be_n  <= ext_be_d;
      uart_rdn      <= rdn_d;
      uart_wrn      <= wrn_d;
      base_drv      <= base_drv_d;
      ext_drv       <= ext_drv_d;
      ack           <= ack_d;
    end
  end

  logic [31:0] reg_rdata, wr_word;

  always_comb begin
    reg_rdata = 32'd0;
    if (cur_addr == UART_STAT)     reg_rdata = {30'd0, uart_dataready, uart_tbre & uart_tsre};
    else if (cur_addr == LED_ADDR) reg_rdata = {16'd0, debug_leds};
    else if (cur_addr == DPY_ADDR) reg_rdata = {24'd0, debug_dpys};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata      <= 32'd0;
      debug_leds <= 16'd0;
      debug_dpys <= 8'd0;
    end else begin
      if (state == IDLE && req && cur_io && !cur_uart) begin
        if (!cur_we)                    rdata      <= reg_rdata;
        else if (cur_addr == LED_ADDR) debug_leds <= wdata[15:0];
        else if (cur_addr == DPY_ADDR) debug_dpys <= wdata[7:0];
      end
      if (state == SRAM && sram_last && !lat_we)
        rdata <= steer_rd(cur_bank ? ext_ram_data : base_ram_data, lat_bm);
      if (state == UART && uart_last && !lat_we)
        rdata <= {24'd0, base_ram_data[7:0]};
    end
  end

  assign wr_word       = cur_uart ? {24'd0, lat_wdata[7:0]} : steer_wr(lat_wdata, lat_bm[3:0]);
  assign base_ram_data = base_drv ? wr_word : 32'hzzzz_zzzz;
  assign ext_ram_data  = ext_drv  ? wr_word : 32'hzzzz_zzzz;
  assign base_ram_addr = lat_addr[SRAM_AW+1:2];
  assign ext_ram_addr  = lat_addr[SRAM_AW+1:2];

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: SRAM/UART pin models plus a word/lane reference model of memory and registers.
// Directed scenarios first, then randomized SRAM and register traffic.
module tb_mem_bus_ctrl;

  localparam int          SRAM_WAIT  = 2;
  localparam int          UART_PULSE = 2;
  localparam int          BUDGET     = 200;
  localparam logic [31:0] UART_A  = 32'hBFD003F8;
  localparam logic [31:0] STAT_A  = 32'hBFD003FC;
  localparam logic [31:0] LED_A   = 32'hBFD00400;
  localparam logic [31:0] DPY_A   = 32'hBFD00408;
  localparam logic [31:0] UNMAP_A = 32'hBFD00500;

  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [4:0]  bytemode = '0;
  logic [31:0] rdata;
  logic        ack;
  wire  [31:0] base_ram_data, ext_ram_data;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic [3:0]  base_ram_be_n, ext_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
  logic        uart_rdn, uart_wrn;
  logic        uart_dataready = 1'b0, uart_tbre = 1'b1, uart_tsre = 1'b1;
  logic [7:0]  uart_rx = 8'hA5;
  logic [15:0] debug_leds;
  logic [7:0]  debug_dpys;

  mem_bus_ctrl #(.SRAM_WAIT(SRAM_WAIT), .UART_PULSE(UART_PULSE)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .bytemode(bytemode), .rdata(rdata), .ack(ack),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
    .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
    .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .uart_dataready(uart_dataready),
    .uart_tbre(uart_tbre), .uart_tsre(uart_tsre),
    .debug_leds(debug_leds), .debug_dpys(debug_dpys)
  );

  always #5 clk = ~clk;

  // Pin-level device models: 64 words per bank, UART RX byte on base_ram_data[7:0].
  logic [31:0] sram [2][64] = '{default: '{default: 32'h0}};
  logic [31:0] uart_tx = '0;
  logic        wrn_early = 1'b0;

  assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? sram[0][base_ram_addr[5:0]] :
                         (!uart_rdn ? {24'h0, uart_rx} : 32'hzzzz_zzzz);
  assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n) ? sram[1][ext_ram_addr[5:0]] : 32'hzzzz_zzzz;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!base_ram_ce_n && !base_ram_we_n && !base_ram_be_n[i])
        sram[0][base_ram_addr[5:0]][8*i +: 8] <= base_ram_data[8*i +: 8];
      if (!ext_ram_ce_n && !ext_ram_we_n && !ext_ram_be_n[i])
        sram[1][ext_ram_addr[5:0]][8*i +: 8] <= ext_ram_data[8*i +: 8];
    end
    if (!uart_wrn) begin
      uart_tx <= base_ram_data;
      if (!(uart_tbre && uart_tsre)) wrn_early <= 1'b1;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [2][64];
  logic [15:0] ref_leds = '0;
  logic [7:0]  ref_dpys = '0;

  int vectors = 0, miscompares = 0;
  int cyc, n_bce, n_bwe, n_boe, n_ece, n_ewe, n_eoe, n_rdn, n_wrn;
  logic [19:0] cap_baddr, cap_eaddr;
  logic [3:0]  cap_bbe, cap_ebe;
  logic [31:0] bus_at_ack, rd;
  logic [15:0] leds_at_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] word, input logic [4:0] bm);
    int          sh;
    logic [31:0] m, v;
    if (bm[3:0] inside {4'd1, 4'd2, 4'd4, 4'd8}) begin
      m = 32'hFF;
      sh = (bm[3:0] == 4'd1) ? 0 : (bm[3:0] == 4'd2) ? 8 : (bm[3:0] == 4'd4) ? 16 : 24;
    end else if (bm[3:0] inside {4'd3, 4'd12}) begin
      m = 32'hFFFF;
      sh = (bm[3:0] == 4'd3) ? 0 : 16;
    end else begin
      return word;
    end
    v = (word >> sh) & m;
    if (!bm[4] && ((v & ((m >> 1) + 1)) != 0)) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] model_write(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] mask);
    logic [31:0] src, res;
    if (mask inside {4'd1, 4'd2, 4'd4, 4'd8}) src = {24'h0, d[7:0]} * 32'h01010101;
    else if (mask inside {4'd3, 4'd12})       src = {16'h0, d[15:0]} * 32'h00010001;
    else                                      src = d;
    res = old;
    for (int i = 0; i < 4; i++)
      if (mask[i]) res[8*i +: 8] = src[8*i +: 8];
    return res;
  endfunction

  task automatic sample();
    if (!base_ram_ce_n) begin n_bce++; cap_baddr = base_ram_addr; cap_bbe = base_ram_be_n; end
    if (!base_ram_we_n) n_bwe++;
    if (!base_ram_oe_n) n_boe++;
    if (!ext_ram_ce_n) begin n_ece++; cap_eaddr = ext_ram_addr; cap_ebe = ext_ram_be_n; end
    if (!ext_ram_we_n) n_ewe++;
    if (!ext_ram_oe_n) n_eoe++;
    if (!uart_rdn) n_rdn++;
    if (!uart_wrn) n_wrn++;
  endtask

  task automatic start_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [4:0] bm);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; bytemode = bm;
    @(posedge clk); #1;
    req = 1'b0; we = $urandom; addr = $urandom; wdata = $urandom; bytemode = 5'($urandom);
    {n_bce, n_bwe, n_boe, n_ece, n_ewe, n_eoe, n_rdn, n_wrn} = '0;
    cap_baddr = '0; cap_eaddr = '0; cap_bbe = 4'hF; cap_ebe = 4'hF;
    cyc = 1;
  endtask

  task automatic wait_ack(output logic [31:0] r);
    forever begin
      sample();
      if (ack) break;
      if (cyc >= BUDGET) begin check("ack_timeout", {31'd0, ack}, 32'd1); break; end
      @(posedge clk); #1;
      cyc++;
    end
    r = rdata;
    bus_at_ack = base_ram_data;
    leds_at_ack = debug_leds;
    @(posedge clk); #1;
    check("ack_single", {31'd0, ack}, 32'd0);
  endtask

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [4:0] bm, output logic [31:0] r);
    start_access(w, a, d, bm);
    wait_ack(r);
  endtask

  logic [3:0] masks [8] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15, 4'd5};

  initial begin
    int n_ack;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 64; i++) ref_mem[b][i] = 32'h0;

    #12;
    check("reset_strobes", {24'd0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n,
                            ext_ram_oe_n, ext_ram_we_n, uart_rdn, uart_wrn}, 32'hFF);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_regs", {8'd0, debug_leds, debug_dpys}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Word write then read on the base bank
    do_access(1'b1, 32'h80000010, 32'hDEADBEEF, 5'h0F, rd);
    ref_mem[0][4] = 32'hDEADBEEF;
    check("wr_latency", 32'(cyc), 32'(SRAM_WAIT + 1));
    check("wr_base_ce", 32'(n_bce), 32'(SRAM_WAIT));
    check("wr_base_we", 32'(n_bwe), 32'(SRAM_WAIT));
    check("wr_ext_idle", 32'(n_ece + n_ewe + n_eoe), 32'd0);
    check("wr_addr", {12'd0, cap_baddr}, 32'd4);
    check("wr_bus_hold", bus_at_ack, 32'hDEADBEEF);
    do_access(1'b0, 32'h80000010, 32'h0, 5'h0F, rd);
    check("rd_latency", 32'(cyc), 32'(SRAM_WAIT + 1));
    check("rd_base_oe", 32'(n_boe), 32'(SRAM_WAIT));
    check("rd_word", rd, 32'hDEADBEEF);

    // Byte store to ext bank, then lb / lbu
    do_access(1'b1, 32'h80400003, 32'h00000080, 5'h08, rd);
    ref_mem[1][0] = model_write(ref_mem[1][0], 32'h80, 4'h8);
    check("sb_ext_be", {28'd0, cap_ebe}, 32'h7);
    check("sb_base_idle", 32'(n_bce), 32'd0);
    do_access(1'b0, 32'h80400003, 32'h0, 5'h08, rd);
    check("lb", rd, 32'hFFFFFF80);
    do_access(1'b0, 32'h80400003, 32'h0, 5'h18, rd);
    check("lbu", rd, 32'h00000080);

    // UART write held off by tsre
    uart_tbre = 1'b1; uart_tsre = 1'b0;
    start_access(1'b1, UART_A, 32'h00000041, 5'h0F);
    for (int k = 0; k < 5; k++) begin sample(); @(posedge clk); #1; cyc++; end
    check("uart_wrn_blocked", 32'(n_wrn), 32'd0);
    uart_tsre = 1'b1;
    wait_ack(rd);
    check("uart_wrn_width", 32'(n_wrn), 32'(UART_PULSE));
    check("uart_tx", uart_tx, 32'h00000041);
    check("uart_wrn_early", {31'd0, wrn_early}, 32'd0);
    check("uart_sram_idle", 32'(n_bce + n_ece), 32'd0);

    // Status and UART read
    uart_dataready = 1'b1;
    do_access(1'b0, STAT_A, 32'h0, 5'h0F, rd);
    check("stat_rd", rd, 32'h3);
    check("stat_latency", 32'(cyc), 32'd1);
    do_access(1'b0, UART_A, 32'h0, 5'h0F, rd);
    check("uart_rd", rd, 32'h000000A5);
    check("uart_rdn_width", 32'(n_rdn), 32'(UART_PULSE));

    // LED register
    do_access(1'b1, LED_A, 32'h00001234, 5'h0F, rd);
    ref_leds = 16'h1234;
    check("led_at_ack", {16'd0, leds_at_ack}, 32'h1234);
    do_access(1'b0, LED_A, 32'h0, 5'h0F, rd);
    check("led_rd", rd, 32'h00001234);

    // Reset during the second SRAM cycle of a write
    start_access(1'b1, 32'h80000014, 32'hCAFEF00D, 5'h0F);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_base_strobes", {30'd0, base_ram_ce_n, base_ram_we_n}, 32'h3);
    check("rst_leds", {16'd0, debug_leds}, 32'd0);
    ref_leds = '0; ref_dpys = '0;
    n_ack = 0;
    repeat (3) begin @(posedge clk); #1; if (ack) n_ack++; end
    check("rst_no_ack", 32'(n_ack), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_access(1'b1, 32'h80000014, 32'h11223344, 5'h0F, rd);
    ref_mem[0][5] = 32'h11223344;
    check("post_rst_lat", 32'(cyc), 32'(SRAM_WAIT + 1));
    do_access(1'b0, 32'h80000014, 32'h0, 5'h0F, rd);
    check("post_rst_rd", rd, 32'h11223344);

    // Randomized traffic
    for (int it = 0; it < 120; it++) begin
      int          kind, bank, idx, sel;
      logic [31:0] a, d, e;
      logic [4:0]  bm;
      kind = $urandom_range(0, 9);
      d = $urandom;
      if (kind <= 6) begin
        bank = $urandom_range(0, 1);
        idx  = $urandom_range(0, 63);
        a    = 32'h80000000 | (32'(bank) << 22) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
        bm   = {1'($urandom_range(0, 1)), masks[$urandom_range(0, 7)]};
        do_access(kind < 4, a, d, bm, rd);
        check("rnd_sram_lat", 32'(cyc), 32'(SRAM_WAIT + 1));
        check("rnd_ce_sel", 32'(bank ? n_ece : n_bce), 32'(SRAM_WAIT));
        check("rnd_ce_other", 32'(bank ? n_bce : n_ece), 32'd0);
        if (kind < 4) ref_mem[bank][idx] = model_write(ref_mem[bank][idx], d, bm[3:0]);
        else          check("rnd_sram_rd", rd, model_read(ref_mem[bank][idx], bm));
      end else if (kind == 7) begin
        a = $urandom_range(0, 1) ? LED_A : DPY_A;
        do_access(1'b1, a, d, 5'h0F, rd);
        if (a == LED_A) ref_leds = d[15:0]; else ref_dpys = d[7:0];
        check("rnd_reg_lat", 32'(cyc), 32'd1);
        check("rnd_regs", {8'd0, debug_leds, debug_dpys}, {8'd0, ref_leds, ref_dpys});
      end else if (kind == 8) begin
        uart_dataready = $urandom; uart_tbre = $urandom; uart_tsre = $urandom;
        sel = $urandom_range(0, 3);
        a = (sel == 0) ? LED_A : (sel == 1) ? DPY_A : (sel == 2) ? STAT_A : UNMAP_A;
        e = (sel == 0) ? 32'(ref_leds) : (sel == 1) ? 32'(ref_dpys) :
            (sel == 2) ? ((uart_dataready ? 32'd2 : 32'd0) + ((uart_tbre && uart_tsre) ? 32'd1 : 32'd0)) :
            32'd0;
        do_access(1'b0, a, 32'h0, 5'h0F, rd);
        check("rnd_reg_rd", rd, e);
      end else begin
        do_access(1'b1, UNMAP_A, d, 5'h0F, rd);
        check("rnd_unmapped_wr", {8'd0, debug_leds, debug_dpys}, {8'd0, ref_leds, ref_dpys});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
